// File: rtl/obi_slave_be.sv
// obi_slave_be: OBI subordinate over a word-addressed RAM with byte-enable writes.
// Define OBI_SLAVE_BE_ASSERT_EN to compile in protocol assertions.
module obi_slave_be #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int AUSER_WIDTH = 0,
    parameter int WUSER_WIDTH = 0,
    parameter int RUSER_WIDTH = 0,
    parameter int ID_WIDTH    = 0,
    parameter int ACHK_WIDTH  = 0,
    parameter int RCHK_WIDTH  = 0,
    parameter bit COMB_GNT    = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RESP = 2'b01;

    // Sideband widths are reserved; no ports exist for them.
    if (AUSER_WIDTH + WUSER_WIDTH + RUSER_WIDTH + ID_WIDTH + ACHK_WIDTH + RCHK_WIDTH != 0) begin : g_reserved
    end

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];
    logic [1:0] state;
    logic w_hs;
    logic w_in_range;
    logic [IDX_W-1:0] w_idx;

    assign obi_gnt_o  = COMB_GNT ? (obi_req_i && state == IDLE) : (state == IDLE);
    assign w_hs       = obi_req_i && obi_gnt_o;
    assign w_in_range = obi_addr_i < ADDR_WIDTH'(MEM_DEPTH);
    assign w_idx      = obi_addr_i[IDX_W-1:0];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= IDLE;
            obi_rvalid_o <= 1'b0;
            obi_rdata_o  <= '0;
            obi_err_o    <= 1'b0;
        end else if (state == IDLE) begin
            if (w_hs) begin
                state        <= RESP;
                obi_rvalid_o <= 1'b1;
                obi_rdata_o  <= w_in_range ? (obi_we_i ? '0 : mem[w_idx]) : DATA_WIDTH'(32'hBADCAB1E);
                obi_err_o    <= !w_in_range;
            end
        end else if (state == RESP) begin
            if (obi_rready_i) begin
                state        <= IDLE;
                obi_rvalid_o <= 1'b0;
            end
        end else begin
            state        <= IDLE;
            obi_rvalid_o <= 1'b0;
        end
    end

    // Storage is deliberately unreset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (reset_ni && w_hs && obi_we_i && w_in_range)
            for (int i = 0; i < BE_W; i++)
                if (obi_be_i[i]) mem[w_idx][8*i +: 8] <= obi_wdata_i[8*i +: 8];
    end

`ifdef OBI_SLAVE_BE_ASSERT_EN
    a_req_stable: assert property (@(posedge clk_i) disable iff (!reset_ni)
        obi_req_i && !obi_gnt_o |=> obi_req_i && $stable(obi_addr_i) && $stable(obi_we_i)
            && $stable(obi_be_i) && $stable(obi_wdata_i))
        else $error("obi_slave_be: A-channel changed before grant");
    a_resp_stable: assert property (@(posedge clk_i) disable iff (!reset_ni)
        obi_rvalid_o && !obi_rready_i |=> obi_rvalid_o && $stable(obi_rdata_o) && $stable(obi_err_o))
        else $error("obi_slave_be: R-channel changed while stalled");
    a_state_legal: assert property (@(posedge clk_i) disable iff (!reset_ni)
        state == IDLE || state == RESP)
        else $error("obi_slave_be: illegal state");
`endif
endmodule

// File: tb/tb_obi_slave_be.sv
// tb_obi_slave_be: directed self-checking bench for obi_slave_be.
module tb_obi_slave_be;
    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        obi_req_i = 1'b0;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i = '0;
    logic        obi_we_i = 1'b0;
    logic [3:0]  obi_be_i = '0;
    logic [31:0] obi_wdata_i = '0;
    logic        obi_rvalid_o;
    logic        obi_rready_i = 1'b1;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    int errors = 0;
    int checks = 0;

    obi_slave_be dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o),
        .obi_addr_i(obi_addr_i), .obi_we_i(obi_we_i), .obi_be_i(obi_be_i),
        .obi_wdata_i(obi_wdata_i), .obi_rvalid_o(obi_rvalid_o), .obi_rready_i(obi_rready_i),
        .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic single(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        obi_req_i = 1'b1; obi_we_i = we; obi_addr_i = addr; obi_be_i = be; obi_wdata_i = wd;
        tick();
        obi_req_i = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_state", 32'(dut.state), 32'h0);
        chk("rst_rvalid", 32'(obi_rvalid_o), 32'h0);
        chk("rst_err", 32'(obi_err_o), 32'h0);
        chk("rst_rdata", obi_rdata_o, 32'h0);
        chk("rst_gnt", 32'(obi_gnt_o), 32'h1);
        reset_ni = 1'b1;
        tick();
        // preload through the bus
        single(1'b1, 32'h4, 4'hF, 32'hDA7A5EAD); tick();
        single(1'b1, 32'h0, 4'hF, 32'h11111111); tick();
        single(1'b1, 32'hFF, 4'hF, 32'hCAFEF00D); tick();

        single(1'b0, 32'h4, 4'h0, 32'h0);
        chk("rd4_rvalid", 32'(obi_rvalid_o), 32'h1);
        chk("rd4_rdata", obi_rdata_o, 32'hDA7A5EAD);
        chk("rd4_err", 32'(obi_err_o), 32'h0);
        chk("rd4_gnt_busy", 32'(obi_gnt_o), 32'h0);
        tick();
        chk("rd4_rvalid_fall", 32'(obi_rvalid_o), 32'h0);
        chk("rd4_rdata_hold", obi_rdata_o, 32'hDA7A5EAD);
        chk("rd4_gnt_back", 32'(obi_gnt_o), 32'h1);

        single(1'b0, 32'hFFFF_FFFF, 4'h0, 32'h0);
        chk("oor_rvalid", 32'(obi_rvalid_o), 32'h1);
        chk("oor_rdata", obi_rdata_o, 32'hBADCAB1E);
        chk("oor_err", 32'(obi_err_o), 32'h1);
        tick();

        single(1'b0, 32'hFF, 4'h0, 32'h0);
        chk("rd255_rdata", obi_rdata_o, 32'hCAFEF00D);
        chk("rd255_err", 32'(obi_err_o), 32'h0);
        tick();

        single(1'b1, 32'h100, 4'hF, 32'h0);
        chk("wr256_err", 32'(obi_err_o), 32'h1);
        chk("wr256_rdata", obi_rdata_o, 32'hBADCAB1E);
        chk("wr256_mem0", dut.mem[0], 32'h11111111);
        tick();

        // write request held while a stalled read is pending
        obi_rready_i = 1'b0;
        single(1'b0, 32'h4, 4'h0, 32'h0);
        obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h2; obi_be_i = 4'hF; obi_wdata_i = 32'h1337C0DE;
        obi_rready_i = 1'b1;
        chk("held_gnt0", 32'(obi_gnt_o), 32'h0);
        tick();
        chk("held_idle", 32'(dut.state), 32'h0);
        chk("held_gnt1", 32'(obi_gnt_o), 32'h1);
        tick();
        obi_req_i = 1'b0;
        chk("held_mem2", dut.mem[2], 32'h1337C0DE);
        chk("held_rvalid", 32'(obi_rvalid_o), 32'h1);
        chk("held_rdata", obi_rdata_o, 32'h0);
        chk("held_err", 32'(obi_err_o), 32'h0);
        tick();

        single(1'b1, 32'h2, 4'b0101, 32'hAAAAAAAA);
        chk("be_mem2", dut.mem[2], 32'h13AAC0AA);
        chk("be_err", 32'(obi_err_o), 32'h0);
        tick();

        obi_rready_i = 1'b0;
        single(1'b0, 32'h2, 4'h0, 32'h0);
        chk("stall_rdata0", obi_rdata_o, 32'h13AAC0AA);
        obi_req_i = 1'b1; obi_addr_i = 32'h4; obi_we_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rvalid", 32'(obi_rvalid_o), 32'h1);
            chk("stall_rdata", obi_rdata_o, 32'h13AAC0AA);
            chk("stall_gnt", 32'(obi_gnt_o), 32'h0);
        end
        obi_req_i = 1'b0;
        obi_rready_i = 1'b1;
        tick();
        chk("stall_release_state", 32'(dut.state), 32'h0);
        chk("stall_release_rvalid", 32'(obi_rvalid_o), 32'h0);

        obi_rready_i = 1'b0;
        single(1'b0, 32'h4, 4'h0, 32'h0);
        chk("mid_rvalid", 32'(obi_rvalid_o), 32'h1);
        #2 reset_ni = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(obi_rvalid_o), 32'h0);
        chk("mid_rst_rdata", obi_rdata_o, 32'h0);
        chk("mid_rst_state", 32'(dut.state), 32'h0);
        chk("mid_rst_mem", dut.mem[2], 32'h13AAC0AA);
        #3 reset_ni = 1'b1;
        obi_rready_i = 1'b1;
        tick();
        single(1'b0, 32'h2, 4'h0, 32'h0);
        chk("post_rst_rd", obi_rdata_o, 32'h13AAC0AA);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
